// File: rtl/if_fetch_stage_if.sv
// I-cache request bus between the fetch stage and the instruction cache.
// The fetch stage is the master; the cache returns data and a miss flag.
interface if_fetch_stage_if;
  logic        ICACHE_ren;
  logic        ICACHE_wen;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_wdata;
  logic [31:0] ICACHE_rdata;
  logic        ICACHE_stall;

  modport master (
    output ICACHE_ren,
    output ICACHE_wen,
    output ICACHE_addr,
    output ICACHE_wdata,
    input  ICACHE_rdata,
    input  ICACHE_stall
  );

  modport slave (
    input  ICACHE_ren,
    input  ICACHE_wen,
    input  ICACHE_addr,
    input  ICACHE_wdata,
    output ICACHE_rdata,
    output ICACHE_stall
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, I-cache request, IF/ID register.
// A small FSM rides out multi-cycle misses and parks redirects seen mid-miss.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013,
  parameter bit          SWAP_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_stall,
  input  logic        hazard_flush,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        mem_stall,
  if_fetch_stage_if.master icache,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_pc4,
  output logic [31:0] IF_ID_inst,
  output logic        IF_ID_valid,
  output logic        fetch_stall
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_MISS,
    S_MISS_REDIR
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend_pc;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_pc4;
  logic [31:0] r_ifid_inst;
  logic        r_ifid_valid;

  logic        w_redirect;
  logic        w_hold;
  logic [31:0] w_target;
  logic [31:0] w_pc4;
  logic [31:0] w_inst;

  assign w_redirect = branch_flag & ~hazard_stall;
  assign w_hold     = hazard_stall | mem_stall;
  assign w_target   = branch_target & ~32'h3;
  assign w_pc4      = r_pc + 32'd4;

  logic [31:0] w_rd;
  assign w_rd = icache.ICACHE_rdata;

  // Memory words arrive little-endian; the decoder wants them swapped.
  assign w_inst = SWAP_ENDIAN ?
    {w_rd[7:0], w_rd[15:8], w_rd[23:16], w_rd[31:24]} :
    w_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_pend_pc    <= 32'h0;
      r_ifid_pc    <= 32'h0;
      r_ifid_pc4   <= 32'h0;
      r_ifid_inst  <= NOP_INST;
      r_ifid_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_FETCH, S_MISS: begin
          if (icache.ICACHE_stall) begin
            if (w_redirect) begin
              r_pend_pc <= w_target;
              r_state   <= S_MISS_REDIR;
            end else begin
              r_state   <= S_MISS;
            end
          end else begin
            r_state <= S_FETCH;
            if (w_redirect) begin
              r_pc         <= w_target;
              r_ifid_inst  <= NOP_INST;
              r_ifid_valid <= 1'b0;
            end else if (w_hold) begin
              r_pc <= r_pc;
            end else if (hazard_flush) begin
              r_pc         <= w_pc4;
              r_ifid_inst  <= NOP_INST;
              r_ifid_valid <= 1'b0;
            end else begin
              r_pc         <= w_pc4;
              r_ifid_pc    <= r_pc;
              r_ifid_pc4   <= w_pc4;
              r_ifid_inst  <= w_inst;
              r_ifid_valid <= 1'b1;
            end
          end
        end
        S_MISS_REDIR: begin
          if (icache.ICACHE_stall) begin
            if (w_redirect) r_pend_pc <= w_target;
          end else begin
            // Returned word belongs to the abandoned path.
            r_pc         <= r_pend_pc;
            r_ifid_inst  <= NOP_INST;
            r_ifid_valid <= 1'b0;
            r_state      <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign icache.ICACHE_ren   = ~rst;
  assign icache.ICACHE_wen   = 1'b0;
  assign icache.ICACHE_addr  = r_pc[31:2];
  assign icache.ICACHE_wdata = 32'h0;

  assign fetch_stall = icache.ICACHE_stall;
  assign IF_ID_pc    = r_ifid_pc;
  assign IF_ID_pc4   = r_ifid_pc4;
  assign IF_ID_inst  = r_ifid_inst;
  assign IF_ID_valid = r_ifid_valid;

endmodule
